pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/galetron_pkg.sv | 13 +
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/flag_register.sv | 30 +++
 rtl/pc_sequencer.sv | 98 +++++++++
 tb/tb_pc_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/galetron_pkg.sv
// Shared sequencer definitions: FSM state encoding and default widths.
package galetron_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 10;
  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_IO = 2'd1,
    ST_HALT    = 2'd2
  } seq_state_e;

endpackage : galetron_pkg

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> sequencer bundle.
//   master: control side; drives requests, target, ALU result, operator pulses.
//   slave : sequencer side; drives pc, flags, halted, waiting, branch_taken.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = galetron_pkg::ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = galetron_pkg::DATA_W_DEFAULT
);

  logic              jump;
  logic              bzero;
  logic              bnegative;
  logic              HLT;
  logic              enable;
  logic [ADDR_W-1:0] mainAddress;
  logic [DATA_W-1:0] alu_result;
  logic              wait_input;
  logic              input_confirm;
  logic              resume;

  logic [ADDR_W-1:0] pc;
  logic              flag_zero;
  logic              flag_negative;
  logic              halted;
  logic              waiting;
  logic              branch_taken;

  modport master (
    output jump, bzero, bnegative, HLT, enable, mainAddress, alu_result,
           wait_input, input_confirm, resume,
    input  pc, flag_zero, flag_negative, halted, waiting, branch_taken
  );

  modport slave (
    input  jump, bzero, bnegative, HLT, enable, mainAddress, alu_result,
           wait_input, input_confirm, resume,
    output pc, flag_zero, flag_negative, halted, waiting, branch_taken
  );

endinterface : pc_sequencer_if

// File: rtl/flag_register.sv
// ALU zero/negative flag storage.
//   clock, reset  : clock, async active-low reset
//   load          : capture flags from alu_result on this edge
//   alu_result    : current ALU output
//   flag_zero/neg : registered flags
module flag_register
  import galetron_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] alu_result,
  output logic              flag_zero,
  output logic              flag_negative
);

  // Flags hold unless the sequencer asks for a load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flag_zero     <= 1'b0;
      flag_negative <= 1'b0;
    end else if (load) begin
      flag_zero     <= (alu_result == '0);
      flag_negative <= alu_result[DATA_W-1];
    end
  end

endmodule : flag_register

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with RUN / WAIT_IO / HALT control.
//   clock, reset : clock, async active-low reset
//   bus (slave)  : requests/target/ALU result in; pc, flags, status out
module pc_sequencer
  import galetron_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              branch_q, branch_d;
  logic              flag_load_c;
  logic              flag_zero, flag_negative;
  logic              redirect_c;

  // Increment wraps naturally at 2^ADDR_W.
  assign pc_inc = pc_q + ADDR_W'(1);

  // Branch conditions see the registered flags, never this cycle's ALU result.
  assign redirect_c = bus.jump
                    | (bus.bzero & flag_zero)
                    | (bus.bnegative & flag_negative);

  // State, pc and redirect pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      pc_q     <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      branch_q <= branch_d;
    end
  end

  // Next-state / next-pc selection.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    branch_d    = 1'b0;
    flag_load_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        flag_load_c = bus.enable;
        if (bus.HLT) begin
          state_d = ST_HALT;
        end else if (bus.wait_input && !bus.input_confirm) begin
          state_d = ST_WAIT_IO;
        end else if (redirect_c) begin
          pc_d     = bus.mainAddress;
          branch_d = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end
      ST_WAIT_IO: begin
        if (bus.input_confirm) begin
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        // resume beats any HLT still asserted this cycle.
        if (bus.resume) begin
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  flag_register #(
    .DATA_W (DATA_W)
  ) u_flag_register (
    .clock         (clock),
    .reset         (reset),
    .load          (flag_load_c),
    .alu_result    (bus.alu_result),
    .flag_zero     (flag_zero),
    .flag_negative (flag_negative)
  );

  assign bus.pc            = pc_q;
  assign bus.flag_zero     = flag_zero;
  assign bus.flag_negative = flag_negative;
  assign bus.halted        = (state_q == ST_HALT);
  assign bus.waiting       = (state_q == ST_WAIT_IO);
  assign bus.branch_taken  = branch_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a behavioural model of the sequencing rules.
module tb_pc_sequencer;
  import galetron_pkg::*;

  localparam int unsigned AW = ADDR_W_DEFAULT;
  localparam int unsigned DW = DATA_W_DEFAULT;
  localparam int          PC_MOD = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pc_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pc_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_pc;
  bit m_fz, m_fn, m_halted, m_waiting, m_branch;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_fz = 0; m_fn = 0; m_halted = 0; m_waiting = 0; m_branch = 0;
  endtask

  // One rising edge of the sequencing rules, using inputs as seen at the edge.
  task automatic model_edge();
    bit nz, nn;
    m_branch = 0;
    if (m_halted) begin
      if (bus.resume) begin
        m_pc = (m_pc + 1) % PC_MOD;
        m_halted = 0;
      end
    end else if (m_waiting) begin
      if (bus.input_confirm) begin
        m_pc = (m_pc + 1) % PC_MOD;
        m_waiting = 0;
      end
    end else begin
      nz = m_fz; nn = m_fn;
      if (bus.enable) begin
        nz = (bus.alu_result == 0);
        nn = bus.alu_result[DW-1];
      end
      if (bus.HLT)
        m_halted = 1;
      else if (bus.wait_input && !bus.input_confirm)
        m_waiting = 1;
      else if (bus.jump || (bus.bzero && m_fz) || (bus.bnegative && m_fn)) begin
        m_pc = int'(bus.mainAddress);
        m_branch = 1;
      end else
        m_pc = (m_pc + 1) % PC_MOD;
      m_fz = nz; m_fn = nn;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_pc"},     32'(bus.pc),            32'(m_pc));
    check_eq({tag, "_fz"},     32'(bus.flag_zero),     32'(m_fz));
    check_eq({tag, "_fn"},     32'(bus.flag_negative), 32'(m_fn));
    check_eq({tag, "_halted"}, 32'(bus.halted),        32'(m_halted));
    check_eq({tag, "_wait"},   32'(bus.waiting),       32'(m_waiting));
    check_eq({tag, "_br"},     32'(bus.branch_taken),  32'(m_branch));
  endtask

  task automatic drive_idle();
    bus.jump = 0; bus.bzero = 0; bus.bnegative = 0; bus.HLT = 0; bus.enable = 0;
    bus.mainAddress = '0; bus.alu_result = '0; bus.wait_input = 0;
    bus.input_confirm = 0; bus.resume = 0;
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic jump_to(input int addr);
    drive_idle();
    bus.jump = 1; bus.mainAddress = AW'(addr);
    step("jmp");
    drive_idle();
  endtask

  initial begin
    int pc_before;
    drive_idle();
    model_reset();

    // Reset held: everything zero.
    repeat (3) @(negedge clock);
    check_all("rst");
    reset = 1'b1;
    check_eq("rel_pc0", 32'(bus.pc), 32'd0);
    for (int i = 1; i < 5; i++) begin
      step("idle");
      check_eq("idle_seq", 32'(bus.pc), 32'(i));
    end

    // Branch on zero, taken.
    bus.enable = 1; bus.alu_result = '0;
    step("setz");
    drive_idle();
    bus.bzero = 1; bus.mainAddress = AW'('h155);
    step("bz");
    check_eq("bz_pc", 32'(bus.pc), 32'h155);
    check_eq("bz_br", 32'(bus.branch_taken), 32'd1);
    drive_idle();
    step("bz_after");
    check_eq("bz_br_clr", 32'(bus.branch_taken), 32'd0);

    // Branch on zero, not taken.
    bus.enable = 1; bus.alu_result = DW'(5);
    step("setnz");
    drive_idle();
    pc_before = int'(bus.pc);
    bus.bzero = 1; bus.mainAddress = AW'('h155);
    step("bznt");
    check_eq("bznt_pc", 32'(bus.pc), 32'((pc_before + 1) % PC_MOD));
    check_eq("bznt_br", 32'(bus.branch_taken), 32'd0);

    // Branch on negative to top of memory, then wrap.
    drive_idle();
    bus.enable = 1; bus.alu_result = 32'h8000_0000;
    step("setn");
    drive_idle();
    bus.bnegative = 1; bus.mainAddress = AW'('h3FF);
    step("bn");
    check_eq("bn_pc", 32'(bus.pc), 32'h3FF);
    drive_idle();
    step("wrap0");
    check_eq("wrap_pc0", 32'(bus.pc), 32'h000);
    step("wrap1");
    check_eq("wrap_pc1", 32'(bus.pc), 32'h001);

    // WAIT_IO at pc=7.
    jump_to(7);
    bus.wait_input = 1;
    repeat (4) begin
      step("wio");
      check_eq("wio_pc", 32'(bus.pc), 32'd7);
      check_eq("wio_wait", 32'(bus.waiting), 32'd1);
    end
    bus.input_confirm = 1;
    step("wio_cf");
    check_eq("wio_cf_pc", 32'(bus.pc), 32'd8);
    check_eq("wio_cf_wait", 32'(bus.waiting), 32'd0);
    drive_idle();
    step("wio_post");

    // HALT at pc=12, jump ignored, resume beats HLT.
    jump_to(12);
    bus.HLT = 1;
    step("hlt");
    bus.jump = 1; bus.mainAddress = AW'('h2AA);
    repeat (10) begin
      step("hlt_hold");
      check_eq("hlt_pc", 32'(bus.pc), 32'd12);
      check_eq("hlt_flag", 32'(bus.halted), 32'd1);
    end
    bus.jump = 0; bus.resume = 1;
    step("resume");
    check_eq("res_pc", 32'(bus.pc), 32'd13);
    check_eq("res_halted", 32'(bus.halted), 32'd0);
    drive_idle();
    step("res_post");

    // Asynchronous reset in the middle of HALT.
    bus.HLT = 1;
    step("hlt2");
    drive_idle();
    @(posedge clock);
    model_edge();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_eq("arst_pc", 32'(bus.pc), 32'd0);
    check_eq("arst_halted", 32'(bus.halted), 32'd0);
    @(negedge clock);
    check_all("arst");
    reset = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      bus.jump          = ($urandom_range(0, 7) == 0);
      bus.bzero         = ($urandom_range(0, 3) == 0);
      bus.bnegative     = ($urandom_range(0, 3) == 0);
      bus.HLT           = ($urandom_range(0, 19) == 0);
      bus.enable        = ($urandom_range(0, 1) == 0);
      bus.mainAddress   = AW'($urandom_range(0, PC_MOD - 1));
      r = $urandom_range(0, 3);
      bus.alu_result    = (r == 0) ? '0 : (r == 1) ? (DW'($urandom) | 32'h8000_0000) : DW'($urandom);
      bus.wait_input    = ($urandom_range(0, 9) == 0);
      bus.input_confirm = ($urandom_range(0, 3) == 0);
      bus.resume        = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_sequencer
